amm2axi: RTL and testbench

Avalon-MM slave to AXI4-Lite master bridge: the inverse of the AXI4-Lite-to-Avalon bridge in the same library. It lets an Avalon-MM master, such as a soft CPU data port or a DMA, reach AXI4-Lite peripherals. Each Avalon transfer becomes exactly one AXI4-Lite transaction, with one transaction outstanding at a time. The bridge stalls the Avalon side with `amm_waitrequest` until the AXI response is returned.

---
 rtl/amm2axi.sv | 175 +++++++++++++++++
 tb/tb_amm2axi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/amm2axi.sv
// Avalon-MM slave to AXI4-Lite master bridge, one transaction outstanding at a time.
// Optional `AMM2AXI_RESP_EN adds amm_response_o carrying the mapped AXI response.
module amm2axi #(
  parameter int unsigned P_ASIZE  = 32,
  parameter int unsigned P_DBYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  // Avalon-MM slave
  input  logic [P_ASIZE-1:0]      amm_address_i,
  input  logic                    amm_write_i,
  input  logic                    amm_read_i,
  input  logic [P_DBYTES*8-1:0]   amm_writedata_i,
  input  logic [P_DBYTES-1:0]     amm_byteenable_i,
  output logic [P_DBYTES*8-1:0]   amm_readdata_o,
  output logic                    amm_waitrequest_o,
`ifdef AMM2AXI_RESP_EN
  output logic [1:0]              amm_response_o,
`endif
  // AXI4-Lite write address / data / response
  output logic [P_ASIZE-1:0]      axi_awaddr_o,
  output logic [2:0]              axi_awprot_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [P_DBYTES*8-1:0]   axi_wdata_o,
  output logic [P_DBYTES-1:0]     axi_wstrb_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic                    axi_bvalid_i,
  input  logic [1:0]              axi_bresp_i,
  output logic                    axi_bready_o,
  // AXI4-Lite read address / data
  output logic [P_ASIZE-1:0]      axi_araddr_o,
  output logic [2:0]              axi_arprot_o,
  output logic [2:0]              axi_arsize_o,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  input  logic                    axi_rvalid_i,
  input  logic [P_DBYTES*8-1:0]   axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,
  output logic                    axi_rready_o
);

  localparam int unsigned DW = P_DBYTES * 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWreq  = 3'd1;
  localparam logic [2:0] StWresp = 3'd2;
  localparam logic [2:0] StRreq  = 3'd3;
  localparam logic [2:0] StRresp = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               arvalid_q, arvalid_d;
  logic [P_ASIZE-1:0] addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [P_DBYTES-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        // Write wins when both strobes are up; the read stays pending on the Avalon side.
        if (amm_write_i) begin
          addr_d    = amm_address_i;
          wdata_d   = amm_writedata_i;
          wstrb_d   = amm_byteenable_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StWreq;
        end else if (amm_read_i) begin
          addr_d    = amm_address_i;
          arvalid_d = 1'b1;
          state_d   = StRreq;
        end
      end
      StWreq: begin
        if (awvalid_q && axi_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready_i)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = StWresp;
      end
      StWresp: begin
        if (axi_bvalid_i) state_d = StDone;
      end
      StRreq: begin
        if (axi_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = StRresp;
        end
      end
      StRresp: begin
        if (axi_rvalid_i) begin
          rdata_d = axi_rdata_i;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef AMM2AXI_RESP_EN
  logic [1:0] resp_q, resp_d;

  // EXOKAY folds into OKAY; error codes pass through unchanged.
  function automatic logic [1:0] map_resp(input logic [1:0] r);
    return r[1] ? r : 2'b00;
  endfunction

  always_comb begin
    resp_d = resp_q;
    if (state_q == StWresp && axi_bvalid_i)      resp_d = map_resp(axi_bresp_i);
    else if (state_q == StRresp && axi_rvalid_i) resp_d = map_resp(axi_rresp_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) resp_q <= 2'b00;
    else         resp_q <= resp_d;
  end

  assign amm_response_o = (state_q == StDone) ? resp_q : 2'b00;
`else
  logic unused_resp;
  assign unused_resp = ^{axi_bresp_i, axi_rresp_i};
`endif

  assign amm_readdata_o    = rdata_q;
  assign amm_waitrequest_o = (state_q != StDone);

  assign axi_awaddr_o  = addr_q;
  assign axi_araddr_o  = addr_q;
  assign axi_awprot_o  = 3'b000;
  assign axi_arprot_o  = 3'b000;
  assign axi_arsize_o  = 3'($clog2(P_DBYTES));
  assign axi_awvalid_o = awvalid_q;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_bready_o  = (state_q == StWresp);
  assign axi_rready_o  = (state_q == StRresp);

endmodule

// File: tb/tb_amm2axi.sv
// Directed bench for amm2axi: write/read latency, split AW/W, priority, async reset.
// Response checks are compiled in when AMM2AXI_RESP_EN is defined.
module tb_amm2axi;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] amm_address;
  logic        amm_write, amm_read;
  logic [31:0] amm_writedata;
  logic [3:0]  amm_byteenable;
  logic [31:0] amm_readdata;
  logic        amm_waitrequest;
`ifdef AMM2AXI_RESP_EN
  logic [1:0]  amm_response;
`endif
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot, arsize;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  amm2axi #(.P_ASIZE(32), .P_DBYTES(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .amm_address_i    (amm_address),
    .amm_write_i      (amm_write),
    .amm_read_i       (amm_read),
    .amm_writedata_i  (amm_writedata),
    .amm_byteenable_i (amm_byteenable),
    .amm_readdata_o   (amm_readdata),
    .amm_waitrequest_o(amm_waitrequest),
`ifdef AMM2AXI_RESP_EN
    .amm_response_o   (amm_response),
`endif
    .axi_awaddr_o     (awaddr),
    .axi_awprot_o     (awprot),
    .axi_awvalid_o    (awvalid),
    .axi_awready_i    (awready),
    .axi_wdata_o      (wdata),
    .axi_wstrb_o      (wstrb),
    .axi_wvalid_o     (wvalid),
    .axi_wready_i     (wready),
    .axi_bvalid_i     (bvalid),
    .axi_bresp_i      (bresp),
    .axi_bready_o     (bready),
    .axi_araddr_o     (araddr),
    .axi_arprot_o     (arprot),
    .axi_arsize_o     (arsize),
    .axi_arvalid_o    (arvalid),
    .axi_arready_i    (arready),
    .axi_rvalid_i     (rvalid),
    .axi_rdata_i      (rdata),
    .axi_rresp_i      (rresp),
    .axi_rready_o     (rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    amm_address = '0; amm_write = 0; amm_read = 0; amm_writedata = '0; amm_byteenable = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    #2;
    check("rst_waitreq", amm_waitrequest, 1);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("rst_readdata", amm_readdata, 0);
    check("rst_addr_data", {awaddr, wdata, wstrb}, 68'h0);
    check("const_prot_size", {awprot, arprot, arsize}, 9'b000_000_010);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_waitreq", amm_waitrequest, 1);

    // Minimum-latency write
    amm_address = 32'h40; amm_writedata = 32'hDEADBEEF; amm_byteenable = 4'hF; amm_write = 1;
    awready = 1; wready = 1;
    tick();
    check("w1_valids", {awvalid, wvalid, arvalid}, 3'b110);
    check("w1_awaddr", awaddr, 32'h40);
    check("w1_wdata_wstrb", {wdata, wstrb}, {32'hDEADBEEF, 4'hF});
    check("w1_wait_t0", amm_waitrequest, 1);
    bvalid = 1;
    tick();
    check("w1_hs_done", {awvalid, wvalid, bready}, 3'b001);
    check("w1_wait_t1", amm_waitrequest, 1);
    tick();
    check("w1_wait_low", amm_waitrequest, 0);
    check("w1_bready_off", bready, 0);
`ifdef AMM2AXI_RESP_EN
    check("w1_resp_okay", amm_response, 2'b00);
`endif
    amm_write = 0; bvalid = 0;
    tick();
    check("w1_wait_back", amm_waitrequest, 1);

    // W handshake four cycles ahead of AW
    amm_address = 32'h44; amm_writedata = 32'hA5A50001; amm_byteenable = 4'h3; amm_write = 1;
    awready = 0; wready = 1;
    tick();
    check("w2_valids", {awvalid, wvalid}, 2'b11);
    tick();
    check("w2_w_done", {awvalid, wvalid}, 2'b10);
    wready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w2_aw_held", {awvalid, wvalid, bready, amm_waitrequest}, 4'b1001);
    end
    awready = 1;
    tick();
    check("w2_aw_done", {awvalid, wvalid, bready}, 3'b001);
    check("w2_wstrb", wstrb, 4'h3);
    bvalid = 1; bresp = 2'b10;
    tick();
    check("w2_wait_low", amm_waitrequest, 0);
`ifdef AMM2AXI_RESP_EN
    check("w2_resp_slverr", amm_response, 2'b10);
`endif
    amm_write = 0; bvalid = 0; bresp = 2'b00;
    tick();
    check("w2_one_b", {amm_waitrequest, bready}, 2'b10);
`ifdef AMM2AXI_RESP_EN
    check("w2_resp_idle", amm_response, 2'b00);
`endif

    // Read with stalled AR and five R wait cycles
    amm_address = 32'h10; amm_read = 1; arready = 0;
    tick();
    check("r1_arvalid", {arvalid, awvalid}, 2'b10);
    check("r1_araddr", araddr, 32'h10);
    tick();
    check("r1_ar_stable", arvalid, 1);
    arready = 1;
    tick();
    check("r1_ar_done", {arvalid, rready}, 2'b01);
    arready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r1_r_wait", {rready, amm_waitrequest, arvalid}, 3'b110);
    end
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b01;
    tick();
    check("r1_wait_low", amm_waitrequest, 0);
    check("r1_readdata", amm_readdata, 32'h12345678);
`ifdef AMM2AXI_RESP_EN
    check("r1_resp_exokay", amm_response, 2'b00);
`endif
    amm_read = 0; rvalid = 0; rdata = 32'h0; rresp = 2'b00;
    tick();
    check("r1_hold", {amm_waitrequest, amm_readdata}, {1'b1, 32'h12345678});

    // Simultaneous write and read: write first, read follows
    amm_address = 32'h80; amm_writedata = 32'h11223344; amm_byteenable = 4'hF;
    amm_write = 1; amm_read = 1;
    awready = 1; wready = 1; bvalid = 1; arready = 1; rvalid = 1; rdata = 32'hCAFEF00D;
    tick();
    check("p_write_first", {awvalid, wvalid, arvalid}, 3'b110);
    tick();
    check("p_wresp", bready, 1);
    tick();
    check("p_w_done", amm_waitrequest, 0);
    amm_write = 0;
    tick();
    check("p_idle", {amm_waitrequest, arvalid}, 2'b10);
    tick();
    check("p_read_issue", {arvalid, awvalid, araddr}, {2'b10, 32'h80});
    tick();
    check("p_rresp", rready, 1);
    tick();
    check("p_r_done", {amm_waitrequest, amm_readdata}, {1'b0, 32'hCAFEF00D});
    amm_read = 0; bvalid = 0; rvalid = 0;
    tick();

    // Asynchronous reset while waiting for B
    amm_address = 32'h20; amm_writedata = 32'h55; amm_byteenable = 4'h1; amm_write = 1;
    tick();
    tick();
    check("rs_in_wresp", {bready, amm_waitrequest}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("rs_async", {awvalid, wvalid, arvalid, bready, amm_waitrequest}, 5'b00001);
    check("rs_readdata", amm_readdata, 0);
    @(negedge clk);
    reset = 1'b0; amm_write = 0;
    @(negedge clk);
    check("rs_idle", {bready, amm_waitrequest}, 2'b01);
    amm_address = 32'h30; amm_read = 1; arready = 1; rvalid = 1; rdata = 32'h0BADCAFE;
    tick();
    check("rs_read_ar", {arvalid, araddr}, {1'b1, 32'h30});
    tick();
    tick();
    check("rs_read_done", {amm_waitrequest, amm_readdata}, {1'b0, 32'h0BADCAFE});
    amm_read = 0; rvalid = 0;
    tick();
    check("rs_final_idle", amm_waitrequest, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
